// File: rtl/sig_debounce.sv
// sig_debounce: synchronizes an async level into clk and rejects pulses shorter than DEB_CYCLES clocks
module sig_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 1000,
    parameter int   CNT_W       = 16,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic sig_out,
    output logic busy
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEB_CYCLES - 1);
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic s;
    assign s    = sync[SYNC_STAGES-1];
    assign busy = s ^ sig_out;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sync <= {SYNC_STAGES{RST_VAL}};
        else       sync <= {sync[SYNC_STAGES-2:0], sig_in};
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt     <= '0;
            sig_out <= RST_VAL;
        end else if (!busy) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt     <= '0;
            sig_out <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
endmodule
